// File: rtl/ray_angle_sequencer.sv
// Per-frame ray generator: latches the heading on start and issues one ray angle per slice.
// Optional `RAY_QUADRANT_EN adds a registered ray_quadrant output tracking ray_angle_X.
module ray_angle_sequencer #(
    parameter int NUM_SLICES   = 160,
    parameter int HALF_FOV_DEG = 30,
    parameter int STEP_MILLI   = 375
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [8:0] player_angle_X,
    input  logic [9:0] player_angle_Y,
    input  logic       ray_ready,
    output logic       ray_valid,
    output logic [8:0] ray_angle_X,
    output logic [9:0] ray_angle_Y,
    output logic [7:0] slice_index,
    output logic       busy,
    output logic       frame_done
`ifdef RAY_QUADRANT_EN
    ,
    output logic [1:0] ray_quadrant
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        DONE
    } state_t;

    localparam logic [7:0] LAST_SLICE = 8'(NUM_SLICES - 1);

    state_t     state;
    logic [8:0] head_x;
    logic [9:0] head_y;
    logic [8:0] left_x;
    logic [8:0] next_x;
    logic [9:0] next_y;

    // Left-edge ray and the per-slice step, both wrapping modulo 360 degrees.
    always_comb begin
        left_x = (head_x >= 9'(HALF_FOV_DEG)) ? head_x - 9'(HALF_FOV_DEG)
                                              : head_x + 9'(360 - HALF_FOV_DEG);
        next_x = ray_angle_X;
        next_y = ray_angle_Y + 10'(STEP_MILLI);
        if (ray_angle_Y >= 10'(1000 - STEP_MILLI)) begin
            next_y = ray_angle_Y - 10'(1000 - STEP_MILLI);
            next_x = (ray_angle_X == 9'd359) ? 9'd0 : ray_angle_X + 9'd1;
        end
    end

`ifdef RAY_QUADRANT_EN
    function automatic logic [1:0] quadrant_of(input logic [8:0] x);
        if (x < 9'd90)
            return 2'd0;
        else if (x < 9'd180)
            return 2'd1;
        else if (x < 9'd270)
            return 2'd2;
        else
            return 2'd3;
    endfunction
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            head_x      <= '0;
            head_y      <= '0;
            ray_valid   <= 1'b0;
            ray_angle_X <= '0;
            ray_angle_Y <= '0;
            slice_index <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
`ifdef RAY_QUADRANT_EN
            ray_quadrant <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        head_x <= player_angle_X;
                        head_y <= player_angle_Y;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    ray_angle_X <= left_x;
                    ray_angle_Y <= head_y;
                    slice_index <= '0;
                    ray_valid   <= 1'b1;
`ifdef RAY_QUADRANT_EN
                    ray_quadrant <= quadrant_of(left_x);
`endif
                    state <= ISSUE;
                end
                ISSUE: begin
                    // ray_valid is always high here, so ready alone marks a transfer.
                    if (ray_ready) begin
                        if (slice_index == LAST_SLICE) begin
                            ray_valid  <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            slice_index <= slice_index + 8'd1;
                            ray_angle_X <= next_x;
                            ray_angle_Y <= next_y;
`ifdef RAY_QUADRANT_EN
                            ray_quadrant <= quadrant_of(next_x);
`endif
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ray_angle_sequencer.md
Name: ray_angle_sequencer

Overview:
- Per-frame ray generator: on a frame-start pulse it latches the player heading and emits one ray angle per screen slice (160 slices across a 60-degree field of view).
- Angles use the team's split decimal fixed-point form: integer degrees plus an unsigned thousandths fraction (0..999).
- Sits directly upstream of the slice-angle subtract and trig/multiply stages; each accepted ray starts one column of wall-distance computation.

Parameters:
- NUM_SLICES, 160, slices per frame (screen width in pixels).
- HALF_FOV_DEG, 30, integer degrees subtracted from the heading to get the left-edge ray.
- STEP_MILLI, 375, per-slice angle increment in thousandths of a degree (0.375 deg); must be < 1000.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  frame-start pulse; sampled only in IDLE.
- player_angle_X  in  9  heading integer degrees, 0..359.
- player_angle_Y  in  10  heading thousandths, 0..999.
- ray_ready  in  1  downstream can accept a ray this cycle.
- ray_valid  out  1  ray_angle_X/Y and slice_index are valid.
- ray_angle_X  out  9  ray integer degrees, 0..359.
- ray_angle_Y  out  10  ray thousandths, 0..999.
- slice_index  out  8  slice number of the current ray, 0..NUM_SLICES-1.
- busy  out  1  high from LOAD through DONE.
- frame_done  out  1  one-cycle pulse after the last ray is accepted.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal latched heading 0.
- FSM has four states: IDLE, LOAD, ISSUE, DONE.
- IDLE to LOAD: on start=1.
  - Latch player_angle_X/Y.
- LOAD to ISSUE: unconditional, one cycle.
  - ray_angle_X = X-HALF_FOV_DEG if X >= HALF_FOV_DEG, else X+360-HALF_FOV_DEG.
  - ray_angle_Y = latched Y; slice_index = 0.
  - ray_valid rises on entry to ISSUE, two clocks after start is sampled.
- In ISSUE, a transfer occurs when ray_valid and ray_ready are both 1 on a rising edge.
- While ray_valid=1 and ray_ready=0, ray_angle_X/Y and slice_index hold stable.
- On transfer with slice_index < NUM_SLICES-1:
  - slice_index +1.
  - sum = ray_angle_Y + STEP_MILLI.
    - If sum >= 1000: Y = sum-1000 and X = X+1.
    - Else: Y = sum.
  - If the X increment makes X equal 360, X becomes 0.
  - ray_valid stays 1, so back-to-back transfers give one ray per clock.
- On transfer with slice_index = NUM_SLICES-1:
  - Go to DONE; ray_valid drops next cycle; angle and index registers hold their last values.
- DONE: frame_done=1 for exactly one cycle, then IDLE; busy drops with the return to IDLE.
- start while busy is ignored and is not queued.
- start held high: one frame per IDLE visit; a new frame begins the cycle after returning to IDLE.
- reset at any state, including mid-frame or with ray_ready low: next cycle IDLE, all outputs 0, partial frame discarded.
- Out-of-range inputs (X>359 or Y>999) are undefined; the sequencer does not check them.

Optional Feature:
- Macro: RAY_QUADRANT_EN.
- Defined:
  - Adds output ray_quadrant [1:0], registered together with ray_angle_X.
  - Values: 0 for [0,90), 1 for [90,180), 2 for [180,270), 3 for [270,360).
  - Reset value 0; holds under backpressure.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Nominal frame: heading 90.000, start, ray_ready=1.
  - Slice0 = 60.000, slice1 = 60.375, slice8 = 63.000, slice159 = 119.625.
  - Exactly 160 transfers; frame_done pulses the cycle after the last transfer.
- Low wrap: heading 10.500 -> slice0 = 340.500; slice52 = 0.000 (X wraps 359 to 0); slice53 = 0.375.
- High wrap: heading 355.000 -> slice0 = 325.000; slice93 = 359.875; slice94 = 0.250.
- Backpressure: hold ray_ready=0 for 5 cycles at slice 3.
  - ray_valid=1; slice_index=3 and angle held.
  - Release -> slice 4 next transfer; total transfers still 160.
- Control: start pulsed at slice 50 -> ignored, frame completes normally.
  - reset at slice 100 -> next cycle ray_valid=0, slice_index=0, busy=0.
  - New start -> slice0 restarts from the newly latched heading.
- RAY_QUADRANT_EN, heading 120.000: slice0 = 90.000 with quadrant 1; slice159 = 149.625 with quadrant 1.
  - Heading 100.000: slice0 = 70.000 with quadrant 0; slice54 = 90.250 with quadrant 1.
